// File: rtl/idma_multi_ch_dispatch.sv
// N-channel iDMA issue dispatcher: routes decoded jobs by channel-select
// field into per-channel queues, hands them to backends, tracks status.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush of every channel
//   issue_*              core-side issue handshake (instr selects channel)
//   issue_accept_o       1 = job queued, 0 = rejected (bad channel)
//   job_valid_o/ready_i  per-channel backend handshake, job_data_o payload
//   done_i, err_i        per-channel backend completion / error pulses
//   start_o, busy_o      handoff pulse, channel has queued or in-flight work
//   done_o, error_o      registered accepted done, sticky error
//   pending_o            per-channel queue occupancy + outstanding jobs
module idma_multi_ch_dispatch #(
    parameter int N_CH       = 4,
    parameter int DEPTH      = 4,
    parameter int MAX_OUT    = 2,
    parameter int INSTR_W    = 32,
    parameter int JOB_W      = 96,
    parameter int CH_SEL_OFF = 25,
    localparam int CH_SEL_W  = $clog2(N_CH),
    localparam int CNT_W     = $clog2(DEPTH + MAX_OUT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [INSTR_W-1:0]      issue_instr_i,
    input  logic [JOB_W-1:0]        issue_data_i,
    output logic                    issue_accept_o,
    output logic [N_CH-1:0]         job_valid_o,
    input  logic [N_CH-1:0]         job_ready_i,
    output logic [N_CH*JOB_W-1:0]   job_data_o,
    input  logic [N_CH-1:0]         done_i,
    input  logic [N_CH-1:0]         err_i,
    output logic [N_CH-1:0]         start_o,
    output logic [N_CH-1:0]         busy_o,
    output logic [N_CH-1:0]         done_o,
    output logic [N_CH-1:0]         error_o,
    output logic [N_CH*CNT_W-1:0]   pending_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int N_SEL = 2 ** CH_SEL_W;

    logic [CH_SEL_W-1:0] sel;
    logic [N_SEL-1:0]    sel_lut;
    logic [N_SEL-1:0]    full_ext;
    logic [N_CH-1:0]     full;
    logic                sel_ok;
    logic                push_any;
    logic                unused_instr;

    assign sel          = issue_instr_i[CH_SEL_OFF +: CH_SEL_W];
    assign unused_instr = ^issue_instr_i;

    // Lookup tables padded to the full select range so an out-of-range
    // channel index reads a defined 0 instead of indexing past N_CH.
    always_comb begin
        sel_lut  = '0;
        full_ext = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_lut[i]  = 1'b1;
            full_ext[i] = full[i];
        end
    end

    assign sel_ok         = sel_lut[sel];
    assign issue_accept_o = sel_ok;
    // Bad channels are swallowed (ready=1, accept=0); clear blocks all.
    assign issue_ready_o  = ~clear_i & (~sel_ok | ~full_ext[sel]);
    assign push_any       = issue_valid_i & issue_ready_o & sel_ok;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [JOB_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W-1:0] rd_ptr;
        logic [QC_W-1:0]  occ;
        logic [OUT_W-1:0] out_cnt;
        logic             push;
        logic             pop;
        logic             empty;
        logic             done_acc;
        logic             done_q;
        logic             err_q;

        assign push     = push_any & (sel == CH_SEL_W'(c));
        assign empty    = (occ == '0);
        assign full[c]  = (occ == QC_W'(DEPTH));

        assign job_valid_o[c] = ~clear_i & ~empty
                              & (out_cnt < OUT_W'(MAX_OUT));
        assign pop        = job_valid_o[c] & job_ready_i[c];
        assign start_o[c] = pop;

        // A done is only meaningful if some job is in flight, counting
        // a handoff in the same cycle.
        assign done_acc = done_i[c] & ((out_cnt != '0) | pop);

        assign job_data_o[c*JOB_W +: JOB_W] = empty ? '0 : mem[rd_ptr];

        assign busy_o[c]  = ~empty | (out_cnt != '0);
        assign done_o[c]  = done_q;
        assign error_o[c] = err_q;
        assign pending_o[c*CNT_W +: CNT_W] = CNT_W'(occ) + CNT_W'(out_cnt);

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_ptr] <= issue_data_i;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
                out_cnt <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if (clear_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
                out_cnt <= '0;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + PTR_W'(push);
                rd_ptr  <= rd_ptr + PTR_W'(pop);
                occ     <= occ + QC_W'(push) - QC_W'(pop);
                out_cnt <= out_cnt + OUT_W'(pop) - OUT_W'(done_acc);
                done_q  <= done_acc;
                err_q   <= err_q | err_i[c] | (done_i[c] & ~done_acc);
            end
        end
    end

endmodule

// File: tb/tb_idma_multi_ch_dispatch.sv
// Self-checking bench for idma_multi_ch_dispatch: directed scenarios then
// random traffic, checked by a counting model and a payload scoreboard.
module tb_idma_multi_ch_dispatch;

    localparam int N_CH       = 4;
    localparam int DEPTH      = 4;
    localparam int MAX_OUT    = 2;
    localparam int INSTR_W    = 32;
    localparam int JOB_W      = 96;
    localparam int CH_SEL_OFF = 25;
    localparam int CH_SEL_W   = 2;
    localparam int CNT_W      = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   clear_i = 1'b0;
    logic                   issue_valid_i = 1'b0;
    logic                   issue_ready_o;
    logic [INSTR_W-1:0]     issue_instr_i = '0;
    logic [JOB_W-1:0]       issue_data_i = '0;
    logic                   issue_accept_o;
    logic [N_CH-1:0]        job_valid_o;
    logic [N_CH-1:0]        job_ready_i = '0;
    logic [N_CH*JOB_W-1:0]  job_data_o;
    logic [N_CH-1:0]        done_i = '0;
    logic [N_CH-1:0]        err_i = '0;
    logic [N_CH-1:0]        start_o;
    logic [N_CH-1:0]        busy_o;
    logic [N_CH-1:0]        done_o;
    logic [N_CH-1:0]        error_o;
    logic [N_CH*CNT_W-1:0]  pending_o;

    idma_multi_ch_dispatch #(
        .N_CH(N_CH), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
        .INSTR_W(INSTR_W), .JOB_W(JOB_W), .CH_SEL_OFF(CH_SEL_OFF)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_data_i(issue_data_i),
        .issue_accept_o(issue_accept_o),
        .job_valid_o(job_valid_o), .job_ready_i(job_ready_i),
        .job_data_o(job_data_o), .done_i(done_i), .err_i(err_i),
        .start_o(start_o), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: job counts per channel, outstanding, flags.
    int occ  [N_CH];
    int outc [N_CH];
    bit errm [N_CH];
    bit donem[N_CH];
    // Scoreboard: payloads expected at each channel's handoff, in order.
    logic [JOB_W-1:0] exp_q [N_CH][$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            occ[c]   = 0;
            outc[c]  = 0;
            errm[c]  = 1'b0;
            donem[c] = 1'b0;
            exp_q[c].delete();
        end
    endtask

    // Payload monitor: every handoff must match the oldest queued payload.
    always @(negedge clk_i) begin
        for (int c = 0; c < N_CH; c++) begin
            if (rst_ni && start_o[c]) begin
                if (exp_q[c].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow ch%0d actual=start required=none", c);
                end else begin
                    logic [JOB_W-1:0] e;
                    e = exp_q[c].pop_front();
                    chk($sformatf("sb_data_ch%0d", c),
                        128'(job_data_o[c*JOB_W +: JOB_W]), 128'(e));
                end
            end
        end
    end

    // One cycle: inputs are already applied; check mid-cycle, then advance
    // the model by the rules of the block.
    task automatic step();
        logic [CH_SEL_W-1:0]   sel;
        bit                    sel_ok;
        bit                    exp_rdy;
        bit                    h;
        bit                    acc;
        logic [N_CH-1:0]       ev, es, eb, ee, ed;
        logic [N_CH*CNT_W-1:0] ep;
        @(negedge clk_i);
        #1;
        sel     = issue_instr_i[CH_SEL_OFF +: CH_SEL_W];
        sel_ok  = (int'(sel) < N_CH);
        exp_rdy = !clear_i && (!sel_ok || occ[sel] < DEPTH);
        for (int c = 0; c < N_CH; c++) begin
            ev[c] = !clear_i && occ[c] > 0 && outc[c] < MAX_OUT;
            es[c] = ev[c] && job_ready_i[c];
            eb[c] = occ[c] > 0 || outc[c] > 0;
            ee[c] = errm[c];
            ed[c] = donem[c];
            ep[c*CNT_W +: CNT_W] = CNT_W'(occ[c] + outc[c]);
        end
        chk("issue_ready", 128'(issue_ready_o), 128'(exp_rdy));
        chk("issue_accept", 128'(issue_accept_o), 128'(sel_ok));
        chk("job_valid", 128'(job_valid_o), 128'(ev));
        chk("start", 128'(start_o), 128'(es));
        chk("busy", 128'(busy_o), 128'(eb));
        chk("error", 128'(error_o), 128'(ee));
        chk("done", 128'(done_o), 128'(ed));
        chk("pending", 128'(pending_o), 128'(ep));
        if (clear_i) begin
            model_reset();
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                h        = es[c];
                acc      = done_i[c] && (outc[c] > 0 || h);
                outc[c]  = outc[c] + int'(h) - int'(acc);
                occ[c]   = occ[c] - int'(h);
                errm[c]  = errm[c] || err_i[c] || (done_i[c] && !acc);
                donem[c] = acc;
            end
            if (issue_valid_i && exp_rdy && sel_ok) begin
                occ[sel]++;
                exp_q[sel].push_back(issue_data_i);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        job_ready_i   = '0;
        done_i        = '0;
        err_i         = '0;
        clear_i       = 1'b0;
    endtask

    task automatic set_issue(input int ch, input logic [JOB_W-1:0] d);
        issue_valid_i = 1'b1;
        issue_instr_i = $urandom;
        issue_instr_i[CH_SEL_OFF +: CH_SEL_W] = CH_SEL_W'(ch);
        issue_data_i  = d;
    endtask

    function automatic logic [JOB_W-1:0] rnd_job();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pending"}, 128'(pending_o), 128'(0));
        chk({tag, "_busy"}, 128'(busy_o), 128'(0));
        chk({tag, "_error"}, 128'(error_o), 128'(0));
        chk({tag, "_done"}, 128'(done_o), 128'(0));
        chk({tag, "_valid"}, 128'(job_valid_o), 128'(0));
        chk({tag, "_start"}, 128'(start_o), 128'(0));
        chk({tag, "_data"}, 128'(job_data_o[127:0]), 128'(0));
    endtask

    task automatic async_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk_zero_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single job to channel 2.
        set_issue(2, 96'hA5);
        step();
        idle();
        chk("tp1_valid2", 128'(job_valid_o[2]), 128'(1));
        chk("tp1_data2", 128'(job_data_o[2*JOB_W +: JOB_W]), 128'(96'hA5));
        chk("tp1_pending2", 128'(pending_o[2*CNT_W +: CNT_W]), 128'(1));
        chk("tp1_busy", 128'(busy_o), 128'(4'b0100));
        step();
        job_ready_i[2] = 1'b1;
        step();
        idle();
        done_i[2] = 1'b1;
        step();
        idle();
        step();

        // Fill channel 0, then offer a fifth job and one to channel 1.
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(0, rnd_job());
            step();
        end
        set_issue(0, rnd_job());
        #1;
        chk("tp2_full_ready", 128'(issue_ready_o), 128'(0));
        step();
        chk("tp2_pending0", 128'(pending_o[CNT_W-1:0]), 128'(4));
        set_issue(1, rnd_job());
        step();

        // Outstanding limit on channel 0, then release one slot.
        idle();
        job_ready_i[0] = 1'b1;
        repeat (4) step();
        done_i[0] = 1'b1;
        step();
        done_i[0] = 1'b0;
        repeat (2) step();
        idle();

        // Same-cycle handoff and done on channel 1; spurious done on 3.
        set_issue(1, rnd_job());
        step();
        idle();
        job_ready_i[1] = 1'b1;
        step();
        done_i[1] = 1'b1;
        step();
        idle();
        done_i[3] = 1'b1;
        step();
        idle();
        chk("tp4_err3", 128'(error_o[3]), 128'(1));
        repeat (3) step();
        chk("tp4_err3_sticky", 128'(error_o[3]), 128'(1));

        // Wide select pattern: only the decoded field bits matter.
        issue_valid_i = 1'b1;
        issue_instr_i = $urandom;
        issue_instr_i[CH_SEL_OFF +: 3] = 3'b101;
        issue_data_i  = rnd_job();
        step();
        idle();

        // Clear with queued and outstanding work and a concurrent issue.
        clear_i = 1'b1;
        step();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(0, rnd_job());
            step();
        end
        idle();
        job_ready_i[0] = 1'b1;
        repeat (2) step();
        idle();
        set_issue(0, rnd_job());
        step();
        idle();
        chk("tp6_pending0", 128'(pending_o[CNT_W-1:0]), 128'(5));
        clear_i = 1'b1;
        set_issue(0, rnd_job());
        #1;
        chk("tp6_clear_ready", 128'(issue_ready_o), 128'(0));
        step();
        idle();
        chk("tp6_pending", 128'(pending_o), 128'(0));
        chk("tp6_busy", 128'(busy_o), 128'(0));
        chk("tp6_error", 128'(error_o), 128'(0));

        // Async reset mid-transfer.
        set_issue(3, rnd_job());
        step();
        job_ready_i[3] = 1'b1;
        set_issue(3, rnd_job());
        step();
        async_reset();
        idle();
        step();

        // Random traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            issue_valid_i = ($urandom_range(0, 9) < 6);
            issue_instr_i = $urandom;
            issue_data_i  = rnd_job();
            job_ready_i   = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                done_i[c] = (outc[c] > 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 40) == 0);
                err_i[c]  = ($urandom_range(0, 60) == 0);
            end
            clear_i = ($urandom_range(0, 80) == 0);
            if (cyc == 1500) begin
                async_reset();
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
